// File: rtl/pio_pkg.sv
// Shared register map and edge-mode encodings for the debounced PIO block.
package pio_pkg;

  localparam logic [1:0] ADDR_IN_DATA      = 2'd0;
  localparam logic [1:0] ADDR_OUT_DATA     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

  typedef enum int {
    EDGE_RISING  = 0,
    EDGE_FALLING = 1,
    EDGE_ANY     = 2
  } edge_type_e;

  // True when the transition prev -> cur is one the selected edge mode captures.
  function automatic logic edge_hit(input int edge_type, input logic prev, input logic cur);
    case (edge_type)
      EDGE_RISING:  return cur & ~prev;
      EDGE_FALLING: return ~cur & prev;
      default:      return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/debounced_pio_irq_if.sv
// Avalon-MM register bus of the debounced PIO block; the host is the master,
// the PIO block is the slave and returns readdata one cycle after a read.
interface debounced_pio_irq_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/pio_debounce.sv
// One input channel: two-flop synchronizer followed by an optional stable-count
// debounce filter, compiled in only when PIO_DEBOUNCE_EN is defined.
module pio_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic sync1, sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          deb;

  // The count tracks how long sync2 has disagreed with deb; any agreeing cycle restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      deb <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dout = deb;
`else
  // Without filtering the window length has no effect.
  localparam int unused_deb_cycles = DEB_CYCLES;

  assign dout = sync2;
`endif

endmodule

// File: rtl/debounced_pio_irq.sv
// Avalon-MM PIO with debounced inputs, edge capture and a masked level interrupt.
// Define PIO_DEBOUNCE_EN to enable the per-channel debounce counters.
module debounced_pio_irq
  import pio_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int N_OUT      = 8,
  parameter int DEB_CYCLES = 50000,
  parameter int EDGE_TYPE  = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  debounced_pio_irq_if.slave bus,
  input  logic [N_IN-1:0]    pio_in,
  output logic [N_OUT-1:0]   pio_out,
  output logic               irq
);

  logic [N_IN-1:0] deb;
  logic [N_IN-1:0] deb_q;
  logic [N_IN-1:0] edges;
  logic [N_IN-1:0] edge_cap;
  logic [N_IN-1:0] irq_mask;
  logic [N_IN-1:0] clr_mask;
  logic [31:0]     rd_mux;
  logic            wr_out;
  logic            wr_mask;
  logic            unused_wdata;

  for (genvar i = 0; i < N_IN; i++) begin : g_chan
    pio_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (pio_in[i]),
      .dout   (deb[i])
    );
  end

  assign wr_out   = bus.write && (bus.address == ADDR_OUT_DATA);
  assign wr_mask  = bus.write && (bus.address == ADDR_IRQ_MASK);
  assign clr_mask = (bus.write && (bus.address == ADDR_EDGE_CAPTURE)) ?
                    bus.writedata[N_IN-1:0] : '0;

  // Write-data bits above each register's width are dropped on purpose.
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    edges = '0;
    for (int i = 0; i < N_IN; i++) begin
      edges[i] = edge_hit(EDGE_TYPE, deb_q[i], deb[i]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_IN_DATA:  rd_mux = 32'(deb);
      ADDR_OUT_DATA: rd_mux = 32'(pio_out);
      ADDR_IRQ_MASK: rd_mux = 32'(irq_mask);
      default:       rd_mux = 32'(edge_cap);
    endcase
  end

  // A new edge outranks a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q    <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      deb_q    <= deb;
      edge_cap <= (edge_cap & ~clr_mask) | edges;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_out  <= '0;
      irq_mask <= '0;
    end else begin
      if (wr_out) begin
        pio_out <= bus.writedata[N_OUT-1:0];
      end
      if (wr_mask) begin
        irq_mask <= bus.writedata[N_IN-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else if (bus.read) begin
      bus.readdata <= rd_mux;
    end
  end

endmodule
